matrix_frame_scheduler: RTL
===========================

Name: matrix_frame_scheduler

Overview:
- Double-buffered frame controller that sits in front of the 16x16 red/green LED matrix scan driver.
- Game logic writes pixels and clears rows in a back buffer, then requests a swap. The swap happens only at a scan-frame boundary, so the display never tears.
- Generates the driver's scan enable and tracks the driver's row/frame position in lockstep. The driver must share FREQDIV and reset.

Parameters:
- FREQDIV, 0, same value as the scan driver's FREQDIV; the driver holds each row for 2^FREQDIV scan_en pulses.
- EN_DIV, 1, clock cycles per scan_en pulse (>=1); with 1, scan_en is high every cycle.
- AUTO_CLEAR, 0, when 1, the new back buffer is cleared automatically after every swap.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  pixel write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_row  in  4  pixel row index (first array index)
- wr_col  in  4  pixel column index (bit index within row)
- wr_color  in  2  bit0 = red, bit1 = green; 0 turns the pixel off
- clear_req  in  1  level request to clear the back buffer
- clear_busy  out  1  high while clearing
- swap_req  in  1  level request; hold until swap_ack
- swap_ack  out  1  one-cycle pulse on the cycle the swap takes effect
- scan_en  out  1  enable to the scan driver
- frame_sync  out  1  one-cycle pulse on the last scan_en of each frame
- red_array  out  16x16  displayed red plane, [row][col]
- green_array  out  16x16  displayed green plane, [row][col]

Behaviour:
- Reset (asynchronous): both buffers all zero; front select = 0; FSM = IDLE; prescaler and scan counters 0; scan_en, frame_sync, swap_ack, clear_busy = 0. wr_ready = 1 immediately after reset (IDLE). Assertion mid-clear or mid-wait aborts the operation with no partial swap.
- Prescaler: counts 0..EN_DIV-1; scan_en is high in the cycle the count equals EN_DIV-1.
- Scan counter: FREQDIV+4 bits, increments on scan_en and wraps.
  - frame_sync = scan_en && counter all-ones.
  - Frame length = 16*2^FREQDIV*EN_DIV cycles.
- Buffers: A and B. Front = select ? B : A, driven combinationally to red_array/green_array. Back is the other buffer.
- FSM states:
  - IDLE: wr_ready = 1. An accepted write sets red[row][col] = wr_color[0] and green[row][col] = wr_color[1] in the back buffer at the next edge. If clear_req, go to CLEAR (row 0). Otherwise, if swap_req, go to SWAP_WAIT. clear_req has priority over swap_req when both are high. A write in the same cycle as a request is still performed.
  - CLEAR: wr_ready = 0; clear_busy = 1. Zeroes back row r for r = 0..15, one row per cycle (16 cycles), then returns to IDLE. A held swap_req is serviced afterwards. A clear_req that is still high on return starts another clear.
  - SWAP_WAIT: wr_ready = 0. On a frame_sync cycle: toggle select at that edge and pulse swap_ack in that same cycle. Then go to CLEAR if AUTO_CLEAR, else IDLE. If swap_req already coincides with frame_sync in IDLE, the swap still waits for the next frame boundary (one full frame).
  - The front buffer is never written. During an auto-clear the displayed contents stay stable.
- Latency:
  - Write is visible in the back buffer 1 cycle after acceptance and on the display after the next swap.
  - Swap latency is <= 1 frame after entering SWAP_WAIT.

Decomposition:
- matrix_pkg:
  - MATRIX_DIM = 16 and ROW_W = 4.
  - color_t enum {OFF=0, RED=1, GREEN=2, YELLOW=3}.
  - fsm_t {IDLE, CLEAR, SWAP_WAIT}.
  - plane_t = logic [15:0][15:0].
- Sub-module matrix_scan_timer: prescaler, scan counter, scan_en, frame_sync; parameters FREQDIV and EN_DIV.

Test Plan:
- Reset, then idle 64 cycles (FREQDIV=0, EN_DIV=2) -> scan_en toggles every cycle; frame_sync every 32 cycles; outputs all zero; wr_ready = 1.
- Write (3,5,YELLOW) then swap_req -> arrays unchanged until the frame_sync cycle. swap_ack on that cycle; next cycle red[3][5] = green[3][5] = 1 and all other bits 0.
- clear_req and swap_req high together after writing (0,0,RED) -> clear_busy high exactly 16 cycles. The swap then occurs at the next frame_sync, and the displayed plane is all zero.
- AUTO_CLEAR=1: write (15,15,GREEN), swap, then write attempts during the 16-cycle clear -> wr_ready = 0 and nothing accepted. A second swap shows an empty plane.
- Assert reset during SWAP_WAIT with a pending pixel -> arrays and back buffer zero, no swap_ack, scan counter restarts; the first frame_sync falls 32 cycles after release.
- EN_DIV=1, FREQDIV=2 -> scan_en constantly high; frame_sync every 64 cycles; swap_req held 200 cycles yields exactly one swap_ack per request.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and dimensions for the double-buffered LED matrix frame scheduler.
package matrix_pkg;
  localparam int MATRIX_DIM = 16;
  localparam int ROW_W      = 4;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RED    = 2'd1,
    GREEN  = 2'd2,
    YELLOW = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } fsm_t;

  typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] plane_t;
endpackage

// File: rtl/matrix_scan_timer.sv
// Scan-enable prescaler and row/frame position counter kept in lockstep with the scan driver.
module matrix_scan_timer
  import matrix_pkg::*;
#(
  parameter int FREQDIV = 0,
  parameter int EN_DIV  = 1
) (
  input  logic clk,
  input  logic reset,
  output logic scan_en,
  output logic frame_sync
);

  localparam int PRE_W = (EN_DIV > 1) ? $clog2(EN_DIV) : 1;
  localparam int CNT_W = FREQDIV + ROW_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(EN_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             scan_en_q, scan_en_d;
  logic             frame_sync_q, frame_sync_d;

  // scan_en/frame_sync are registered from the next-cycle count so they line up with pre_q/cnt_q.
  always_comb begin
    pre_d        = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    cnt_d        = cnt_q + CNT_W'(scan_en_q);
    scan_en_d    = (pre_d == PRE_LAST);
    frame_sync_d = scan_en_d && (&cnt_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q        <= '0;
      cnt_q        <= '0;
      scan_en_q    <= 1'b0;
      frame_sync_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      scan_en_q    <= scan_en_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign scan_en    = scan_en_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Double-buffered frame controller: writes/clears go to the back buffer, swaps land on frame boundaries.
module matrix_frame_scheduler
  import matrix_pkg::*;
#(
  parameter int FREQDIV    = 0,
  parameter int EN_DIV     = 1,
  parameter bit AUTO_CLEAR = 1'b0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   wr_valid,
  output logic                                   wr_ready,
  input  logic [3:0]                             wr_row,
  input  logic [3:0]                             wr_col,
  input  logic [1:0]                             wr_color,
  input  logic                                   clear_req,
  output logic                                   clear_busy,
  input  logic                                   swap_req,
  output logic                                   swap_ack,
  output logic                                   scan_en,
  output logic                                   frame_sync,
  output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0]  red_array,
  output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0]  green_array
);

  fsm_t             state_q, state_d;
  logic             sel_q, sel_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic             wr_ready_q, wr_ready_d;
  logic             clear_busy_q, clear_busy_d;
  plane_t           red_a_q, red_a_d, green_a_q, green_a_d;
  plane_t           red_b_q, red_b_d, green_b_q, green_b_d;

  matrix_scan_timer #(
    .FREQDIV (FREQDIV),
    .EN_DIV  (EN_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .frame_sync (frame_sync)
  );

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    clr_row_d = clr_row_q;
    red_a_d   = red_a_q;
    green_a_d = green_a_q;
    red_b_d   = red_b_q;
    green_b_d = green_b_q;

    case (state_q)
      IDLE: begin
        if (wr_valid && wr_ready_q) begin
          if (sel_q) begin
            red_a_d[wr_row][wr_col]   = wr_color[0];
            green_a_d[wr_row][wr_col] = wr_color[1];
          end else begin
            red_b_d[wr_row][wr_col]   = wr_color[0];
            green_b_d[wr_row][wr_col] = wr_color[1];
          end
        end
        if (clear_req) begin
          state_d   = CLEAR;
          clr_row_d = '0;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        if (sel_q) begin
          red_a_d[clr_row_q]   = '0;
          green_a_d[clr_row_q] = '0;
        end else begin
          red_b_d[clr_row_q]   = '0;
          green_b_d[clr_row_q] = '0;
        end
        clr_row_d = clr_row_q + ROW_W'(1);
        if (clr_row_q == ROW_W'(MATRIX_DIM - 1)) state_d = IDLE;
      end
      SWAP_WAIT: begin
        if (frame_sync) begin
          sel_d = ~sel_q;
          if (AUTO_CLEAR) begin
            state_d   = CLEAR;
            clr_row_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ready_d   = (state_d == IDLE);
    clear_busy_d = (state_d == CLEAR);
  end

  // NOTE: the buffers are plain flops feeding the display, so they are reset to guarantee a blank panel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      clr_row_q    <= '0;
      wr_ready_q   <= 1'b1;
      clear_busy_q <= 1'b0;
      red_a_q      <= '0;
      green_a_q    <= '0;
      red_b_q      <= '0;
      green_b_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      clr_row_q    <= clr_row_d;
      wr_ready_q   <= wr_ready_d;
      clear_busy_q <= clear_busy_d;
      red_a_q      <= red_a_d;
      green_a_q    <= green_a_d;
      red_b_q      <= red_b_d;
      green_b_q    <= green_b_d;
    end
  end

  // Both terms are flops; the ack marks the edge at which the front buffer flips.
  assign swap_ack    = (state_q == SWAP_WAIT) && frame_sync;
  assign wr_ready    = wr_ready_q;
  assign clear_busy  = clear_busy_q;
  assign red_array   = sel_q ? red_b_q : red_a_q;
  assign green_array = sel_q ? green_b_q : green_a_q;

endmodule
